// File: rtl/mem_block_adapter_pkg.sv
// Shared cache constants and FSM encoding for the block-to-word memory adapter.
package mem_block_adapter_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int ADR_WIDTH      = 16;
  localparam int OFFSET_WIDTH   = 2;
  localparam int DATA_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int BLOCK_SIZE     = DATA_WIDTH * DATA_PER_BLOCK;
  localparam int BUS_ADR_WIDTH  = ADR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Word address of slot `off` inside block `blk`.
  function automatic logic [ADR_WIDTH-1:0] word_addr(
    input logic [BUS_ADR_WIDTH-1:0] blk,
    input logic [OFFSET_WIDTH-1:0]  off
  );
    return {blk, off};
  endfunction

endpackage

// File: rtl/mem_block_adapter_if.sv
// Cache-side and memory-side bus of the block adapter; mem_err exists only
// when MEM_TIMEOUT_EN is defined.
interface mem_block_adapter_if;
  import mem_block_adapter_pkg::*;

  // Handshake: blk_rd/blk_wr are sampled at a clock edge only while busy is
  // low (never queued); mem_rd/mem_wr stay high until mem_ack is seen in the
  // same cycle; m_ready is a single-cycle completion pulse.
  logic                     blk_rd;
  logic                     blk_wr;
  logic [BUS_ADR_WIDTH-1:0] m_address;
  logic [BLOCK_SIZE-1:0]    m_blockout;
  logic [BLOCK_SIZE-1:0]    m_blockin;
  logic                     m_ready;
  logic                     busy;
  logic [ADR_WIDTH-1:0]     mem_addr;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  logic                     mem_ack;
`ifdef MEM_TIMEOUT_EN
  logic                     mem_err;
`endif

  modport slave (
    input  blk_rd, blk_wr, m_address, m_blockout, mem_rdata, mem_ack,
    output m_blockin, m_ready, busy, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef MEM_TIMEOUT_EN
    , output mem_err
`endif
  );

  modport master (
    output blk_rd, blk_wr, m_address, m_blockout, mem_rdata, mem_ack,
    input  m_blockin, m_ready, busy, mem_addr, mem_rd, mem_wr, mem_wdata
`ifdef MEM_TIMEOUT_EN
    , input mem_err
`endif
  );

endinterface

// File: rtl/mem_block_adapter_block_word_buffer.sv
// Block-wide register with a word-indexed write port and a word-indexed read mux;
// holds the write-back source or the refill block being assembled.
module block_word_buffer
  import mem_block_adapter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BLOCK_SIZE-1:0]   load_block,
  input  logic                    wr_en,
  input  logic [OFFSET_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [OFFSET_WIDTH-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [BLOCK_SIZE-1:0]   merged
);

  logic [BLOCK_SIZE-1:0] block_q;

  // merged shows the block as it will look after this cycle's word write, so
  // the final refill word can be published in the same edge it arrives.
  always_comb begin
    merged = block_q;
    if (wr_en) merged[wr_idx*DATA_WIDTH +: DATA_WIDTH] = wr_data;
  end

  assign rd_data = block_q[rd_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_q <= '0;
    end else if (load) begin
      block_q <= load_block;
    end else if (wr_en) begin
      block_q <= merged;
    end
  end

endmodule

// File: rtl/mem_block_adapter.sv
// Splits cache block refills/write-backs into sequential word transfers.
// Build option MEM_TIMEOUT_EN adds an ack watchdog and the mem_err flag.
module mem_block_adapter
  import mem_block_adapter_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT = 64
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  mem_block_adapter_if.slave  bus,
  output state_t              dbg_state
);

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(DATA_PER_BLOCK - 1);

  state_t                   state;
  logic [OFFSET_WIDTH-1:0]  cnt;
  logic [OFFSET_WIDTH-1:0]  cnt_nxt;
  logic [BUS_ADR_WIDTH-1:0] blk_adr;
  logic                     buf_load;
  logic                     buf_wr;
  logic [DATA_WIDTH-1:0]    buf_rd_data;
  logic [BLOCK_SIZE-1:0]    buf_merged;

`ifdef MEM_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);
  logic [WDOG_W-1:0] wdog;
`endif

  assign cnt_nxt   = cnt + 1'b1;
  assign dbg_state = state;
  assign buf_load  = (state == IDLE) && bus.blk_wr;
  assign buf_wr    = (state == READ) && bus.mem_ack;

  block_word_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_block (bus.m_blockout),
    .wr_en      (buf_wr),
    .wr_idx     (cnt),
    .wr_data    (bus.mem_rdata),
    .rd_idx     (cnt_nxt),
    .rd_data    (buf_rd_data),
    .merged     (buf_merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      blk_adr       <= '0;
      bus.m_blockin <= '0;
      bus.m_ready   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      wdog          <= '0;
      bus.mem_err   <= 1'b0;
`endif
    end else begin
      bus.m_ready <= 1'b0;
      case (state)
        IDLE: begin
          // blk_wr wins a tie; a simultaneous blk_rd is simply dropped.
          if (bus.blk_wr || bus.blk_rd) begin
            blk_adr      <= bus.m_address;
            cnt          <= '0;
            bus.busy     <= 1'b1;
            bus.mem_addr <= word_addr(bus.m_address, '0);
`ifdef MEM_TIMEOUT_EN
            wdog         <= '0;
            bus.mem_err  <= 1'b0;
`endif
            if (bus.blk_wr) begin
              state         <= WRITE;
              bus.mem_wr    <= 1'b1;
              bus.mem_wdata <= bus.m_blockout[DATA_WIDTH-1:0];
            end else begin
              state      <= READ;
              bus.mem_rd <= 1'b1;
            end
          end
        end
        READ, WRITE: begin
          if (bus.mem_ack) begin
            cnt <= cnt_nxt;
`ifdef MEM_TIMEOUT_EN
            wdog <= '0;
`endif
            if (cnt == LAST_WORD) begin
              state       <= DONE;
              bus.mem_rd  <= 1'b0;
              bus.mem_wr  <= 1'b0;
              bus.m_ready <= 1'b1;
              if (state == READ) bus.m_blockin <= buf_merged;
            end else begin
              bus.mem_addr <= word_addr(blk_adr, cnt_nxt);
              if (state == WRITE) bus.mem_wdata <= buf_rd_data;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (wdog == WDOG_LIMIT) begin
            // Abandon the transfer: complete with an error, keep m_blockin.
            state       <= DONE;
            cnt         <= '0;
            wdog        <= '0;
            bus.mem_rd  <= 1'b0;
            bus.mem_wr  <= 1'b0;
            bus.m_ready <= 1'b1;
            bus.mem_err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
